// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-port memory arbiter: requester IDs,
// the idle owner code, FSM state encodings and a one-hot helper.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

    localparam logic [1:0] REQ_IF     = 2'd0;
    localparam logic [1:0] REQ_MEM    = 2'd1;
    localparam logic [1:0] REQ_DBG    = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Requester index to one-hot request vector; the idle code maps to no bits.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] vec;
        case (idx)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection. Priority is MEM > IF > DBG, except that a
// starved DBG port wins outright. Masked requesters never win.
`timescale 1ns/1ps
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
    input  logic       starve_hit,
    output logic [1:0] pick,
    output logic       any
);

    logic [2:0] elig_s;

    // Select the winning requester among the unmasked requests.
    always_comb begin
        elig_s = req & ~mask;
        any    = |elig_s;
        if (starve_hit && elig_s[2]) begin
            pick = REQ_DBG;
        end else if (elig_s[1]) begin
            pick = REQ_MEM;
        end else if (elig_s[0]) begin
            pick = REQ_IF;
        end else if (elig_s[2]) begin
            pick = REQ_DBG;
        end else begin
            pick = OWNER_NONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch, data access and a
// loader/debug port. One transaction at a time, fixed read latency, and a
// registered completion pulse back to the owner.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                Rst,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [1:0]          owner,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

    arb_state_t           state_r;
    logic [1:0]           owner_r;
    logic                 we_q_r;
    logic [LAT_W-1:0]     lat_cnt_r;
    logic [STV_W-1:0]     starve_cnt_r;
    logic [2:0]           gnt_r;
    logic [2:0]           done_r;
    logic                 busy_r;
    logic                 mem_en_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    logic [DATA_W-1:0]    rdata_r;

    logic [2:0]           mask_s;
    logic                 starve_hit_s;
    logic [1:0]           pick_s;
    logic                 any_s;
    logic                 dbg_lose_s;
    logic                 sel_we_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_wdata_s;

    // In DONE the finishing owner still holds req, so its bit is hidden from arbitration.
    always_comb begin
        mask_s = 3'b000;
        if (state_r == ST_DONE) begin
            mask_s = onehot3(owner_r);
        end else begin
            mask_s = 3'b000;
        end
    end

    assign starve_hit_s = (starve_cnt_r == STARVE_TOP);

    mem_arb_pick u_pick (
        .req        (req),
        .mask       (mask_s),
        .starve_hit (starve_hit_s),
        .pick       (pick_s),
        .any        (any_s)
    );

    // DBG loses an arbitration when it competes and someone else wins.
    assign dbg_lose_s = req[2] & ~mask_s[2] & any_s & (pick_s != REQ_DBG);

    // Route the winning requester's command fields toward the grant registers.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        case (pick_s)
            REQ_IF: begin
                sel_we_s    = we[0];
                sel_addr_s  = addr[0*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[0*DATA_W +: DATA_W];
            end
            REQ_MEM: begin
                sel_we_s    = we[1];
                sel_addr_s  = addr[1*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[1*DATA_W +: DATA_W];
            end
            REQ_DBG: begin
                sel_we_s    = we[2];
                sel_addr_s  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Transaction FSM; every output is registered on the transition into its state.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_NONE;
            we_q_r       <= 1'b0;
            lat_cnt_r    <= {LAT_W{1'b0}};
            starve_cnt_r <= {STV_W{1'b0}};
            gnt_r        <= 3'b000;
            done_r       <= 3'b000;
            busy_r       <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
        end else begin
            gnt_r    <= 3'b000;
            done_r   <= 3'b000;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (any_s) begin
                        state_r     <= ST_ISSUE;
                        owner_r     <= pick_s;
                        we_q_r      <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        gnt_r       <= onehot3(pick_s);
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= sel_we_s;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        owner_r <= OWNER_NONE;
                        busy_r  <= 1'b0;
                    end
                    if (any_s && (pick_s == REQ_DBG)) begin
                        starve_cnt_r <= {STV_W{1'b0}};
                    end else if (dbg_lose_s && !starve_hit_s) begin
                        starve_cnt_r <= starve_cnt_r + STV_W'(1);
                    end else begin
                        starve_cnt_r <= starve_cnt_r;
                    end
                end
                ST_ISSUE: begin
                    state_r   <= ST_WAIT;
                    lat_cnt_r <= LAT_INIT;
                end
                ST_WAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        if (!we_q_r) begin
                            rdata_r <= mem_rdata;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r <= ST_DONE;
                        done_r  <= onehot3(owner_r);
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    owner_r <= OWNER_NONE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign owner     = owner_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-cycle-latency memory, a transaction-level
// model checked against the DUT every cycle, and directed scenarios with
// hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MEM_LAT = 2;
    localparam int STARVE_MAX = 4;

    logic            CLK;
    logic            Rst;
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [1:0]      owner;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .Rst(Rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .owner(owner),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 16) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    // Memory under the arbiter: writes commit at the strobe edge, reads appear 2 cycles after mem_en.
    logic [31:0] bmem [0:255];
    logic [31:0] rd_pipe;
    always @(posedge CLK) begin
        if (mem_en && mem_we) bmem[mem_addr[9:2]] <= mem_wdata;
        rd_pipe   <= (mem_en && !mem_we) ? bmem[mem_addr[9:2]] : 32'h0;
        mem_rdata <= rd_pipe;
    end

    // Transaction-level reference: k counts cycles since issue (0 = ISSUE, MEM_LAT+1 = DONE).
    logic [31:0] m_mem [0:255];
    logic        m_active;
    int          m_k;
    int          m_own;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_pend, m_rdata;
    int          m_starve;

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i]  = init_word(i);
            m_mem[i] = init_word(i);
        end
    end

    always @(posedge CLK or posedge Rst) begin : model
        logic [2:0]  elig;
        int          pk;
        logic [31:0] a;
        if (Rst) begin
            m_active <= 1'b0; m_k <= 0; m_own <= 3; m_we <= 1'b0;
            m_addr <= 32'h0; m_wdata <= 32'h0; m_pend <= 32'h0;
            m_rdata <= 32'h0; m_starve <= 0;
        end else if (!m_active || m_k == MEM_LAT + 1) begin
            elig = req;
            if (m_active) elig[m_own] = 1'b0;
            if (elig != 3'b000) begin
                if (elig[2] && m_starve == STARVE_MAX) pk = 2;
                else if (elig[1]) pk = 1;
                else if (elig[0]) pk = 0;
                else pk = 2;
                if (pk == 2) m_starve <= 0;
                else if (elig[2]) m_starve <= (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
                a = addr[pk*32 +: 32];
                m_active <= 1'b1; m_k <= 0; m_own <= pk;
                m_we <= we[pk]; m_addr <= a; m_wdata <= wdata[pk*32 +: 32];
                if (we[pk]) m_mem[a[9:2]] <= wdata[pk*32 +: 32];
                else m_pend <= m_mem[a[9:2]];
            end else begin
                m_active <= 1'b0;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == MEM_LAT + 1 && !m_we) m_rdata <= m_pend;
        end
    end

    // Per-cycle comparison of every DUT output against the reference.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("busy", busy, m_active);
            chk("owner", owner, m_active ? 2'(m_own) : 2'd3);
            chk("gnt", gnt, (m_active && m_k == 0) ? (3'b001 << m_own) : 3'b000);
            chk("done", done, (m_active && m_k == MEM_LAT + 1) ? (3'b001 << m_own) : 3'b000);
            chk("mem_en", mem_en, m_active && m_k == 0);
            chk("mem_we", mem_we, m_active && m_k == 0 && m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("rdata", rdata, m_rdata);
        end
    end

    int g_who[$], g_cyc[$], d_cyc[$];
    int idle_cnt, we_cnt;

    task automatic set_port(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        we[i] = w;
        addr[i*32 +: 32]  = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < 50);
        chk("wait_idle", busy, 1'b0);
        @(posedge CLK); #2;
    endtask

    // Raise reqs, drop non-held bits after their done, stop after n_done completions.
    task automatic run_multi(input logic [2:0] reqs, input logic [2:0] hold, input int n_done);
        int cyc = 0;
        int nd = 0;
        logic [2:0] drop;
        g_who.delete(); g_cyc.delete(); d_cyc.delete();
        idle_cnt = 0; we_cnt = 0;
        req = req | reqs;
        while (nd < n_done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            drop = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (gnt[i]) begin g_who.push_back(i); g_cyc.push_back(cyc); end
                if (done[i]) begin
                    d_cyc.push_back(cyc);
                    nd++;
                    if (!hold[i]) drop[i] = 1'b1;
                end
            end
            if (!busy) idle_cnt++;
            if (mem_we) we_cnt++;
            @(posedge CLK); #2;
            req = req & ~drop;
        end
        chk("run_done_count", nd, n_done);
        req = 3'b000;
        wait_idle();
    endtask

    initial begin : stim
        int n, dcnt;
        Rst = 1'b1; req = 3'b000; we = 3'b000; addr = '0; wdata = '0;
        repeat (3) @(posedge CLK);
        #2 Rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state and idle with no requests.
        @(negedge CLK);
        chk("rst_owner", owner, 2'd3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(posedge CLK); #2;

        // 1. Single read by IF.
        set_port(0, 1'b0, 32'h40, 32'h0);
        run_multi(3'b001, 3'b000, 1);
        chk("t1_gnt_who", (g_who.size() > 0) ? g_who[0] : -1, 0);
        chk("t1_gnt_cyc", (g_cyc.size() > 0) ? g_cyc[0] : -1, 2);
        chk("t1_done_cyc", (d_cyc.size() > 0) ? d_cyc[0] : -1, 5);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_model_rdata", m_rdata, 32'hDEAD_BEEF);

        // 2. Write by MEM, then read it back through IF.
        set_port(1, 1'b1, 32'h80, 32'h1234);
        run_multi(3'b010, 3'b000, 1);
        chk("t2_we_pulses", we_cnt, 1);
        chk("t2_lat", (d_cyc.size() > 0 && g_cyc.size() > 0) ? d_cyc[0] - g_cyc[0] : -1, 3);
        chk("t2_rdata_kept", rdata, 32'hDEAD_BEEF);
        set_port(0, 1'b0, 32'h80, 32'h0);
        run_multi(3'b001, 3'b000, 1);
        chk("t2_readback", rdata, 32'h0000_1234);

        // 3. Simultaneous IF + MEM: MEM first, IF back-to-back.
        set_port(0, 1'b0, 32'h40, 32'h0);
        set_port(1, 1'b0, 32'h44, 32'h0);
        run_multi(3'b011, 3'b000, 2);
        chk("t3_first", (g_who.size() > 0) ? g_who[0] : -1, 1);
        chk("t3_second", (g_who.size() > 1) ? g_who[1] : -1, 0);
        chk("t3_done1_cyc", (d_cyc.size() > 0) ? d_cyc[0] : -1, 5);
        chk("t3_gnt0_cyc", (g_cyc.size() > 1) ? g_cyc[1] : -1, 6);
        chk("t3_idle_cycles", idle_cnt, 1);
        chk("t3_rdata", rdata, 32'hDEAD_BEEF);

        // IF beats DBG.
        set_port(2, 1'b0, 32'h4C, 32'h0);
        run_multi(3'b101, 3'b000, 2);
        chk("prio_first", (g_who.size() > 0) ? g_who[0] : -1, 0);
        chk("prio_second", (g_who.size() > 1) ? g_who[1] : -1, 2);
        chk("prio_rdata", rdata, 32'hC0DE_0013);

        // 4. Starvation: IF and MEM held, DBG wins on the 5th arbitration.
        run_multi(3'b111, 3'b011, 5);
        for (int i = 0; i < 5; i++) begin
            int exp_who;
            exp_who = (i == 4) ? 2 : ((i % 2 == 0) ? 1 : 0);
            chk($sformatf("starve_order_%0d", i), (g_who.size() > i) ? g_who[i] : -1, exp_who);
        end
        // Counter cleared by DBG's grant: MEM wins the next contest again.
        run_multi(3'b111, 3'b011, 2);
        chk("starve_cleared_first", (g_who.size() > 0) ? g_who[0] : -1, 1);
        chk("starve_cleared_second", (g_who.size() > 1) ? g_who[1] : -1, 0);

        // 5. Reset during WAIT.
        set_port(0, 1'b0, 32'h40, 32'h0);
        req = 3'b001;
        n = 0;
        do begin @(negedge CLK); n++; end while (!gnt[0] && n < 20);
        chk("t5_gnt_seen", gnt[0], 1'b1);
        @(posedge CLK); #2;
        Rst = 1'b1;
        @(negedge CLK);
        chk("t5_busy", busy, 1'b0);
        chk("t5_owner", owner, 2'd3);
        chk("t5_done", done, 3'b000);
        chk("t5_mem_en", mem_en, 1'b0);
        chk("t5_rdata", rdata, 32'h0);
        req = 3'b000;
        @(posedge CLK); #2;
        Rst = 1'b0;
        dcnt = 0;
        repeat (6) begin @(negedge CLK); if (done != 3'b000) dcnt++; end
        chk("t5_no_done", dcnt, 0);
        @(posedge CLK); #2;
        set_port(0, 1'b0, 32'h44, 32'h0);
        run_multi(3'b001, 3'b000, 1);
        chk("t5_fresh_rdata", rdata, 32'hC0DE_0011);

        // 6. Early drop of req after grant; fields changed after grant are ignored.
        set_port(0, 1'b0, 32'h48, 32'h0);
        req = 3'b001;
        n = 0;
        do begin @(negedge CLK); n++; end while (!gnt[0] && n < 20);
        chk("t6_gnt_seen", gnt[0], 1'b1);
        @(posedge CLK); #2;
        req = 3'b000;
        set_port(0, 1'b1, 32'h0, 32'hFFFF_FFFF);
        n = 0;
        do begin @(negedge CLK); n++; end while (!done[0] && n < 10);
        chk("t6_done_after_gnt", n, 3);
        chk("t6_rdata", rdata, 32'hC0DE_0012);
        @(negedge CLK);
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_idle_owner", owner, 2'd3);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
